// File: rtl/rms_mean_square_feeder_if.sv
// Sample-in / radicand-out bundle shared by the mean-square feeder, its
// sample source and the downstream sqrt block.
interface rms_mean_square_feeder_if #(
  parameter int WIDTH = 16
);
  logic             sample_valid;
  logic [WIDTH-1:0] sample;
  logic             sqrt_busy;
  logic             sqrt_start;
  logic [WIDTH-1:0] sqrt_rad;
  logic             sat;
  logic             overrun;

  // Environment side: supplies samples and sqrt busy, observes the issue.
  modport master (
    output sample_valid,
    output sample,
    output sqrt_busy,
    input  sqrt_start,
    input  sqrt_rad,
    input  sat,
    input  overrun
  );

  // Feeder side.
  modport slave (
    input  sample_valid,
    input  sample,
    input  sqrt_busy,
    output sqrt_start,
    output sqrt_rad,
    output sat,
    output overrun
  );
endinterface

// File: rtl/rms_mean_square_feeder.sv
// Mean-square feeder for the fixed-point sqrt block: squares signed samples,
// averages them over 2^LOG2N samples and hands the (saturated) radicand to
// the sqrt block with a start/busy handshake. Accumulation never stalls.
module rms_mean_square_feeder #(
  parameter int WIDTH = 16,
  parameter int FBITS = 8,
  parameter int LOG2N = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  rms_mean_square_feeder_if.slave  bus
);

  localparam int SQW  = 2 * WIDTH;
  localparam int ACCW = SQW + LOG2N;
  localparam logic [LOG2N-1:0] LAST_IDX = '1;

  // Input capture
  logic             in_v;
  logic [WIDTH-1:0] in_s;

  // Square stage
  logic [LOG2N-1:0] cnt;
  logic             sq_v;
  logic             sq_last;
  logic [SQW-1:0]   sq_r;
  logic [SQW-1:0]   in_ext;
  logic [SQW-1:0]   sq_full;

  // Accumulate / pending stage
  logic [ACCW-1:0]  acc;
  logic [ACCW-1:0]  total;
  logic [ACCW-1:0]  mean;
  logic [ACCW-1:0]  rad_full;
  logic             rad_sat;
  logic             win_done;
  logic             pending;
  logic [WIDTH-1:0] pend_rad;
  logic             pend_sat;

  // Issue stage
  logic             issue;
  logic             start_r;
  logic [WIDTH-1:0] rad_r;
  logic             sat_r;
  logic             overrun_r;

  // Register the incoming sample so the multiplier sees a clean flop output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_v <= 1'b0;
      in_s <= '0;
    end else begin
      in_v <= bus.sample_valid;
      if (bus.sample_valid) in_s <= bus.sample;
    end
  end

  // Sign-extend to full product width; the low SQW bits of the product are
  // exact for every input, including the most negative sample.
  always_comb begin
    in_ext  = {{WIDTH{in_s[WIDTH-1]}}, in_s};
    sq_full = in_ext * in_ext;
  end

  // Square stage with window position tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      sq_v    <= 1'b0;
      sq_last <= 1'b0;
      sq_r    <= '0;
    end else begin
      sq_v <= in_v;
      if (in_v) begin
        sq_r    <= sq_full;
        sq_last <= (cnt == LAST_IDX);
        cnt     <= cnt + 1'b1;
      end
    end
  end

  // Window sum, mean, Q conversion and saturation detect.
  always_comb begin
    total    = acc + {{LOG2N{1'b0}}, sq_r};
    mean     = total >> LOG2N;
    rad_full = mean >> FBITS;
    rad_sat  = |rad_full[ACCW-1:WIDTH];
    win_done = sq_v && sq_last;
    issue    = pending && !bus.sqrt_busy && !start_r;
  end

  // Accumulator restarts from zero at each window boundary.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (win_done) begin
      acc <= '0;
    end else if (sq_v) begin
      acc <= total;
    end
  end

  // Pending radicand; a new window takes priority over an issue clearing it,
  // so a same-edge issue consumes the old value and the new one stays queued.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending  <= 1'b0;
      pend_rad <= '0;
      pend_sat <= 1'b0;
    end else if (win_done) begin
      pending  <= 1'b1;
      pend_rad <= rad_sat ? '1 : rad_full[WIDTH-1:0];
      pend_sat <= rad_sat;
    end else if (issue) begin
      pending  <= 1'b0;
    end
  end

  // Sticky overrun: a finished window replaced a radicand that never issued.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun_r <= 1'b0;
    end else if (win_done && pending && !issue) begin
      overrun_r <= 1'b1;
    end
  end

  // Start pulse plus held radicand/sat; start self-clears via the issue term.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_r <= 1'b0;
      rad_r   <= '0;
      sat_r   <= 1'b0;
    end else begin
      start_r <= issue;
      if (issue) begin
        rad_r <= pend_rad;
        sat_r <= pend_sat;
      end
    end
  end

  assign bus.sqrt_start = start_r;
  assign bus.sqrt_rad   = rad_r;
  assign bus.sat        = sat_r;
  assign bus.overrun    = overrun_r;

endmodule
